// File: rtl/dispatch_queue_pkg.sv
// Shared core definitions: opcode constants, resource-class bit positions and
// the dispatch-queue entry layout used by both the storage and steering logic.
package dispatch_queue_pkg;

  localparam int DQ_DEPTH_DEF = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int RC_ALU = 0;
  localparam int RC_LSU = 1;
  localparam int RC_MUL = 2;
  localparam int RC_W   = 3;

  typedef struct packed {
    logic [31:0]     inst;
    logic [31:0]     pc;
    logic [RC_W-1:0] rclass;
    logic            br;
  } dq_entry_t;

  // Dispatchable only when exactly one execution class is claimed.
  function automatic logic class_legal(input logic [RC_W-1:0] rc);
    return (rc == 3'b001) || (rc == 3'b010) || (rc == 3'b100);
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Circular entry store with head/tail pointers and occupancy; write lands at
// the edge, head is readable the next cycle. Push/pop are pre-qualified by the caller.
module inst_fifo
  import dispatch_queue_pkg::*;
#(
  parameter  int DEPTH = DQ_DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            flush_i,
  input  logic            push,
  input  dq_entry_t       wr_entry,
  input  logic            pop,
  output dq_entry_t       head_entry,
  output logic [CW-1:0]   count
);

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  dq_entry_t     mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Flush voids any same-cycle push or pop.
  assign do_push = push && !flush_i;
  assign do_pop  = pop && !flush_i && (count != '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush_i) begin
      head_ptr <= tail_ptr;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop)  head_ptr <= head_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[tail_ptr] <= wr_entry;
  end

  assign head_entry = mem[head_ptr];

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: 1-cycle push-to-head latency, steers the head to one
// issue port; holds head until that port's ready, stalls upstream when full.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter  int DEPTH = DQ_DEPTH_DEF,
  parameter  int CNTW  = 32,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            flush_i,
  input  logic            inst_valid_i,
  input  logic [31:0]     inst_i,
  input  logic [31:0]     pc_i,
  input  logic            alu_i,
  input  logic            lsu_i,
  input  logic            mul_i,
  input  logic            br_i,
  output logic            inst_ready_o,
  output logic            alu_valid_o,
  input  logic            alu_ready_i,
  output logic            lsu_valid_o,
  input  logic            lsu_ready_i,
  output logic            mul_valid_o,
  input  logic            mul_ready_i,
  output logic [31:0]     disp_inst_o,
  output logic [31:0]     disp_pc_o,
  output logic            disp_br_o,
  output logic            illegal_o,
  output logic [CW-1:0]   count_o,
  output logic [CNTW-1:0] disp_cnt_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  dq_entry_t wr_entry;
  dq_entry_t head;
  logic      not_empty;
  logic      head_legal;
  logic      push;
  logic      pop;

  always_comb begin
    wr_entry                = '0;
    wr_entry.inst           = inst_i;
    wr_entry.pc             = pc_i;
    wr_entry.rclass[RC_ALU] = alu_i;
    wr_entry.rclass[RC_LSU] = lsu_i;
    wr_entry.rclass[RC_MUL] = mul_i;
    wr_entry.br             = br_i;
  end

  assign inst_ready_o = (count_o < FULL_CNT) && !flush_i;
  assign push         = inst_valid_i && inst_ready_o;

  inst_fifo #(.DEPTH(DEPTH)) u_inst_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .flush_i    (flush_i),
    .push       (push),
    .wr_entry   (wr_entry),
    .pop        (pop),
    .head_entry (head),
    .count      (count_o)
  );

  // Valids come only from stored state so downstream readies can't loop back.
  assign not_empty   = (count_o != '0);
  assign head_legal  = class_legal(head.rclass);
  assign alu_valid_o = not_empty && head_legal && head.rclass[RC_ALU];
  assign lsu_valid_o = not_empty && head_legal && head.rclass[RC_LSU];
  assign mul_valid_o = not_empty && head_legal && head.rclass[RC_MUL];
  assign illegal_o   = not_empty && !head_legal;

  assign pop = (alu_valid_o && alu_ready_i) ||
               (lsu_valid_o && lsu_ready_i) ||
               (mul_valid_o && mul_ready_i);

  assign disp_inst_o = not_empty ? head.inst : '0;
  assign disp_pc_o   = not_empty ? head.pc   : '0;
  assign disp_br_o   = not_empty && head.br;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      disp_cnt_o <= '0;
    end else if (pop && !flush_i) begin
      disp_cnt_o <= disp_cnt_o + CNTW'(1);
    end
  end

endmodule
